// File: rtl/tick_divider.sv
// tick_divider: multi-channel clock-enable generator.
// Each channel emits a one-cycle TICK every act clocks plus a square wave SQ
// that toggles on every TICK. Divisors are written into a shadow register and
// promoted to the active divisor only at a period boundary (wrap) or on CLR,
// so a reload never produces a short or long glitch period.

module tick_divider #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 27,
  parameter int SEL_W = 2,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT =
    {27'd20_000_000, 27'd160_000, 27'd50_000_000, 27'd100_000_000}
) (
  input  logic             M_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [N_CH-1:0]  CH_EN,
  input  logic             DIV_WE,
  input  logic [SEL_W-1:0] DIV_SEL,
  input  logic [CNT_W-1:0] DIV_DATA,
  output logic [N_CH-1:0]  TICK,
  output logic [N_CH-1:0]  SQ
);

  // Reject configurations that could never produce a valid period.
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_init_chk
      if (DIV_INIT[g*CNT_W +: CNT_W] == '0) begin : g_zero_div
        $error("tick_divider: DIV_INIT field %0d is zero", g);
      end
    end
    if ((1 << SEL_W) < N_CH) begin : g_sel_chk
      $error("tick_divider: SEL_W too narrow for N_CH");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [CNT_W-1:0] r_act [N_CH];
  logic [CNT_W-1:0] r_shd [N_CH];
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  r_sq;

  logic [N_CH-1:0]  w_run;
  logic [N_CH-1:0]  w_wrap;
  logic [N_CH-1:0]  w_wr;

  // Per-channel run, wrap detect (full-width compare) and write decode.
  // A select value that matches no channel index simply hits nothing.
  always_comb begin
    w_run  = '0;
    w_wrap = '0;
    w_wr   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_run[i]  = EN & CH_EN[i];
      w_wrap[i] = EN & CH_EN[i] & (r_cnt[i] == (r_act[i] - CNT_W'(1)));
      w_wr[i]   = DIV_WE & (DIV_SEL == SEL_W'(i)) & (DIV_DATA != '0);
    end
  end

  // Counter, divisor and output state for all channels; CLR outranks run.
  always_ff @(posedge M_CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
        r_act[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        r_shd[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      r_tick <= '0;
      r_sq   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (CLR) begin
          // A write landing with CLR is applied straight to the active divisor.
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_sq[i]   <= 1'b0;
          r_act[i]  <= w_wr[i] ? DIV_DATA : r_shd[i];
        end else if (w_wrap[i]) begin
          // The wrap loads the shadow as it stood before any same-edge write.
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_sq[i]   <= ~r_sq[i];
          r_act[i]  <= r_shd[i];
        end else if (w_run[i]) begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
        end else begin
          r_tick[i] <= 1'b0;
        end
        if (w_wr[i]) begin
          r_shd[i] <= DIV_DATA;
        end
      end
    end
  end

  assign TICK = r_tick;
  assign SQ   = r_sq;

endmodule

// File: tb/tb_tick_divider.sv
// Scoreboard bench for tick_divider: the stimulus process pushes the expected
// TICK/SQ for every clock edge, a monitor pops and compares on the falling edge.

module tb_tick_divider;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
  localparam int SEL_W = 3;
  localparam logic [N_CH*CNT_W-1:0] DIV_INIT = {4'd5, 4'd3, 4'd2, 4'd1};

  logic             M_CLK    = 1'b0;
  logic             RST      = 1'b1;
  logic             EN       = 1'b0;
  logic             CLR      = 1'b0;
  logic [N_CH-1:0]  CH_EN    = 4'hF;
  logic             DIV_WE   = 1'b0;
  logic [SEL_W-1:0] DIV_SEL  = 3'd0;
  logic [CNT_W-1:0] DIV_DATA = 4'd0;
  logic [N_CH-1:0]  TICK;
  logic [N_CH-1:0]  SQ;

  tick_divider #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DIV_INIT(DIV_INIT)
  ) dut (
    .M_CLK(M_CLK), .RST(RST), .EN(EN), .CLR(CLR), .CH_EN(CH_EN),
    .DIV_WE(DIV_WE), .DIV_SEL(DIV_SEL), .DIV_DATA(DIV_DATA),
    .TICK(TICK), .SQ(SQ)
  );

  always #5 M_CLK = ~M_CLK;

  typedef struct packed {
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sq;
  } exp_t;

  exp_t  exp_q [$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [N_CH-1:0] sq_m = 4'h0;

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  always @(negedge M_CLK) begin : mon
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (TICK !== e.tick) begin
        errors++;
        $display("FAIL %s TICK: got %b expected %b at %0t", nm, TICK, e.tick, $time);
      end
      checks++;
      if (SQ !== e.sq) begin
        errors++;
        $display("FAIL %s SQ: got %b expected %b at %0t", nm, SQ, e.sq, $time);
      end
    end
  end

  // Hand-derived tick pattern: channel with divisor d ticks when the number of
  // running edges since the last restart is a multiple of d.
  function automatic logic [N_CH-1:0] pattern(input int e, input int d0, input int d1,
                                               input int d2, input int d3);
    logic [N_CH-1:0] p;
    p[0] = (e % d0) == 0;
    p[1] = (e % d1) == 0;
    p[2] = (e % d2) == 0;
    p[3] = (e % d3) == 0;
    return p;
  endfunction

  // Drive one edge of stimulus and queue the response expected after it.
  task automatic step(input string nm, input logic en, input logic clr, input logic we,
                      input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data,
                      input logic [N_CH-1:0] exp_tick);
    exp_t e;
    EN = en; CLR = clr; DIV_WE = we; DIV_SEL = sel; DIV_DATA = data;
    if (clr || RST) begin
      sq_m   = 4'h0;
      e.tick = 4'h0;
    end else begin
      sq_m   = sq_m ^ exp_tick;
      e.tick = exp_tick;
    end
    e.sq = sq_m;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge M_CLK);
    @(negedge M_CLK);
  endtask

  initial begin : stim
    int e;
    logic en;
    logic [N_CH-1:0] t;

    // Reset held: everything zero.
    repeat (2) step("reset", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0);
    RST = 1'b0;

    // Free run with DIV_INIT {5,3,2,1}.
    for (int k = 1; k <= 30; k++)
      step("free_run", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, pattern(k, 1, 2, 3, 5));

    // EN low for 4 edges mid ch3 period: ch3 tick moves from edge 10 to 14.
    step("en_clr", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 4'h0);
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      en = !(k >= 7 && k <= 10);
      if (en) e++;
      step("en_stall", en, 1'b0, 1'b0, 3'd0, 4'd0, en ? pattern(e, 1, 2, 3, 5) : 4'h0);
    end

    // ch3 <= 2 written two edges before its wrap: ticks at 5, then every 2.
    step("wr_clr", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 4'h0);
    for (int k = 1; k <= 14; k++) begin
      t = pattern(k, 1, 2, 3, 5);
      t[3] = (k == 5) || (k > 5 && ((k - 5) % 2) == 0);
      step("wr_early", 1'b1, 1'b0, (k == 3), 3'd3, 4'd2, t);
    end

    // CLR with a write restores ch3 to 5 at once; write on the wrap edge:
    // ticks at 5 and 10, then every 2.
    step("wr_restore", 1'b1, 1'b1, 1'b1, 3'd3, 4'd5, 4'h0);
    for (int k = 1; k <= 17; k++) begin
      t = pattern(k, 1, 2, 3, 5);
      t[3] = (k == 5) || (k == 10) || (k > 10 && ((k - 10) % 2) == 0);
      step("wr_on_wrap", 1'b1, 1'b0, (k == 5), 3'd3, 4'd2, t);
    end

    // Dropped writes: zero data to ch1, out-of-range select 5.
    step("bad_clr", 1'b1, 1'b1, 1'b1, 3'd3, 4'd5, 4'h0);
    for (int k = 1; k <= 23; k++)
      step("bad_wr", 1'b1, 1'b0, (k == 2) || (k == 4),
           (k == 4) ? 3'd5 : 3'd1, (k == 4) ? 4'd4 : 4'd0, pattern(k, 1, 2, 3, 5));

    // CLR at mixed phases (ch1 cnt 1, ch2 cnt 2, ch3 cnt 3), then realign.
    step("clr_mid", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 4'h0);
    for (int k = 1; k <= 12; k++)
      step("realign", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, pattern(k, 1, 2, 3, 5));

    // Writes applied through CLR: divisors become {2,3,3,1}.
    step("clr_wr1", 1'b1, 1'b1, 1'b1, 3'd1, 4'd3, 4'h0);
    step("clr_wr3", 1'b1, 1'b1, 1'b1, 3'd3, 4'd2, 4'h0);
    for (int k = 1; k <= 7; k++)
      step("new_divs", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, pattern(k, 1, 3, 3, 2));

    // Asynchronous reset between edges.
    #2;
    checks++;
    if (TICK[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_tick0: got %b expected 1", TICK[0]);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (TICK !== 4'h0) begin
      errors++;
      $display("FAIL async_rst TICK: got %b expected 0000", TICK);
    end
    checks++;
    if (SQ !== 4'h0) begin
      errors++;
      $display("FAIL async_rst SQ: got %b expected 0000", SQ);
    end
    step("rst_hold", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0);
    RST = 1'b0;
    for (int k = 1; k <= 15; k++)
      step("after_rst", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, pattern(k, 1, 2, 3, 5));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge M_CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
